ysyx_23060020_ifu: RTL and testbench
====================================

// Module: ysyx_23060020_ifu
// PURPOSE
//  Instruction fetch unit; the producer side of the instruction-word interface.
//  - Holds the PC and issues one outstanding fetch at a time to instruction memory (valid/ready request, valid response).
//  - Presents each fetched word (instw) with its PC to the decoder/execute stage over a valid/ready handshake.
//  - Advances PC by 4 on each consumed instruction, or jumps to redirect_pc on a branch/jump.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC of the first fetch after reset
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst_n            in   1   asynchronous, active-low reset
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   memory accepts request
//  imem_req_addr    out  32  fetch address; stable while imem_req_valid=1 and not accepted
//  imem_resp_valid  in   1   response valid; one per accepted request, at least 1 cycle after acceptance
//  imem_resp_data   in   32  fetched instruction word
//  imem_resp_err    in   1   access fault for this response
//  inst_valid       out  1   instw/inst_pc/fetch_err valid to consumer
//  inst_ready       in   1   consumer takes instruction
//  instw            out  32  instruction word (0 when fetch_err=1)
//  inst_pc          out  32  PC of instw
//  fetch_err        out  1   access fault or misaligned PC; qualified by inst_valid
//  redirect         in   1   one-cycle pulse: next PC is redirect_pc
//  redirect_pc      in   32  redirect target
//  halted           out  1   fetch stopped (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=IDLE, stale=0. Outputs 0: imem_req_valid, inst_valid, instw, inst_pc, fetch_err, halted.
//  - imem_req_addr=pc.
//  - States:
//    - IDLE: go to REQ next cycle; if pc[1:0]!=0, go to HOLD with fetch_err=1, instw=0, inst_pc=pc, and issue no request.
//    - REQ: imem_req_valid=1. On req handshake, go to WAIT.
//    - WAIT: on imem_resp_valid, register instw=resp_data (0 if resp_err), fetch_err=resp_err, inst_pc=pc; go to HOLD.
//    - HOLD: inst_valid=1; outputs frozen until inst_ready. On handshake, pc<=pc+4 (mod 2^32) and go to IDLE.
//  - Latency: request accepted in cycle N, response in cycle N+k, inst_valid in cycle N+k+1.
//    - With imem zero-wait (ready=1, resp next cycle) and inst_ready=1: one instruction per 4 cycles.
//  - Redirect (checked in every state; wins over all same-cycle events): pc<=redirect_pc.
//    - IDLE or HOLD: drop inst_valid next cycle (the held instruction is discarded) and go to IDLE.
//      - Redirect together with inst_ready in HOLD: instruction is consumed, but next pc=redirect_pc, not pc+4.
//    - REQ not yet accepted: keep imem_req_valid and the old address until accepted (protocol stability); set stale=1.
//    - WAIT, or REQ accepted in the same cycle: set stale=1.
//      - A response arriving in the redirect cycle itself is also dropped.
//    - While stale=1 in WAIT: the next response is dropped, stale clears, and state goes to IDLE (no inst_valid).
//  - imem_resp_valid outside WAIT is ignored.
//  - Reset assertion mid-fetch aborts immediately; any response after reset release is ignored until a new request.
// CONFIGURATION
//  YSYX_23060020_IFU_EBREAK_HALT_EN
//   - Defined: when an instruction equal to 32'h0010_0073 (ebreak) completes the HOLD handshake, enter HALT.
//     - HALT: no further requests, inst_valid=0, halted=1, redirect ignored; only rst_n exits.
//   - Undefined: ebreak is fetched like any other word; halted is tied to 0.
// TESTING
//  1. Reset release; imem ready=1 with 1-cycle response; inst_ready=1
//     -> request addresses 0x8000_0000 then 0x8000_0004; inst_pc values match.
//  2. inst_ready=0 for 5 cycles in HOLD
//     -> instw/inst_pc/inst_valid stable; imem_req_valid=0 throughout.
//  3. redirect=1, redirect_pc=0x8000_0100 in WAIT, same cycle as imem_resp_valid
//     -> that response dropped, no inst_valid; next request addr 0x8000_0100.
//  4. redirect (pc 0x8000_0200) together with inst_ready in HOLD at pc 0x8000_0008
//     -> next request 0x8000_0200, not 0x8000_000C.
//  5. imem_resp_err=1 -> inst_valid=1, fetch_err=1, instw=0.
//     Redirect to 0x8000_0102 -> no request; inst_valid with fetch_err=1, inst_pc=0x8000_0102.
//  6. Macro defined, memory returns 0x0010_0073 and it is consumed
//     -> halted=1; no further requests for 20 cycles, even with redirect pulsed.

Source files
------------

// File: rtl/ysyx_23060020_ifu.sv
// Instruction fetch unit: holds the PC, issues one outstanding imem fetch and hands the word to decode.
// Optional feature: define YSYX_23060020_IFU_EBREAK_HALT_EN to stop fetching after a consumed ebreak.
module ysyx_23060020_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instw,
    output logic [31:0] inst_pc,
    output logic        fetch_err,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] instw_q, instw_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        err_q, err_d;
    logic        stale_q, stale_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instw_d    = instw_q;
        inst_pc_d  = inst_pc_q;
        err_d      = err_q;
        stale_d    = stale_q;

        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (pc_q[1:0] != 2'b00) begin
                    state_d   = S_HOLD;
                    instw_d   = 32'h0;
                    err_d     = 1'b1;
                    inst_pc_d = pc_q;
                end else begin
                    state_d    = S_REQ;
                    req_addr_d = pc_q;
                end
            end
            S_REQ: begin
                // The request address stays on req_addr_q, so a redirect here only marks the fetch stale.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    stale_d = 1'b1;
                end
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (imem_resp_valid) begin
                        stale_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        stale_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    stale_d = 1'b0;
                    if (stale_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_HOLD;
                        instw_d   = imem_resp_err ? 32'h0 : imem_resp_data;
                        err_d     = imem_resp_err;
                        inst_pc_d = pc_q;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_IDLE;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_IDLE;
`ifdef YSYX_23060020_IFU_EBREAK_HALT_EN
                    if (instw_q == EBREAK) begin
                        state_d = S_HALT;
                    end
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instw_q    <= 32'h0;
            inst_pc_q  <= 32'h0;
            err_q      <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instw_q    <= instw_d;
            inst_pc_q  <= inst_pc_d;
            err_q      <= err_d;
            stale_q    <= stale_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = (state_q == S_REQ) ? req_addr_q : pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign instw          = instw_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_err      = err_q;

`ifdef YSYX_23060020_IFU_EBREAK_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060020_ifu.sv
// Self-checking bench for ysyx_23060020_ifu: table of fetches checked against a response scoreboard,
// followed by hand-written redirect, misalignment, ebreak and mid-fetch reset sequences.
module tb_ysyx_23060020_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instw;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        err;
    } exp_t;

    typedef struct {
        int          delay;
        logic        err;
        int          stall;
        logic [31:0] pc;
        logic        ferr;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];

    int   compared;
    int   mismatched;
    int   resp_delay;
    logic resp_err_cfg;
    logic force_ebreak;

    ysyx_23060020_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instw          (instw),
        .inst_pc        (inst_pc),
        .fetch_err      (fetch_err),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h0F0F_0000;
    endfunction

    // Memory model: samples the handshake mid-cycle, answers resp_delay cycles after acceptance.
    initial begin : responder
        logic        hs;
        logic [31:0] a;
        logic [31:0] pa;
        int          cnt;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        cnt = 0;
        pa  = 32'h0;
        forever begin
            @(negedge clk);
            hs = imem_req_valid && imem_req_ready;
            a  = imem_req_addr;
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (hs) begin
                cnt = resp_delay;
                pa  = a;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = force_ebreak ? EBREAK : mem_word(pa);
                    imem_resp_err   = resp_err_cfg;
                    sb.push_back('{pa, resp_err_cfg ? 32'h0 : imem_resp_data, resp_err_cfg});
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output logic ok);
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (inst_valid) break;
        end
        ok = inst_valid;
    endtask

    task automatic wait_req(output logic [31:0] addr, output logic saw_valid);
        saw_valid = 1'b0;
        addr      = 32'hDEAD_DEAD;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (inst_valid) saw_valid = 1'b1;
            if (imem_req_valid) begin
                addr = imem_req_addr;
                break;
            end
        end
    endtask

    task automatic fetch_one(input vec_t v, input int idx);
        logic        ok;
        logic        stable;
        logic [31:0] s_w;
        logic [31:0] s_pc;
        logic        s_e;
        exp_t        e;
        resp_delay   = v.delay;
        resp_err_cfg = v.err;
        inst_ready   = (v.stall == 0);
        wait_valid(ok);
        check($sformatf("vec%0d_valid", idx), ok, 1);
        s_w    = instw;
        s_pc   = inst_pc;
        s_e    = fetch_err;
        stable = 1'b1;
        for (int j = 0; j < v.stall; j++) begin
            @(negedge clk);
            if (!inst_valid || instw !== s_w || inst_pc !== s_pc || fetch_err !== s_e || imem_req_valid)
                stable = 1'b0;
        end
        if (v.stall > 0) check($sformatf("vec%0d_hold_stable", idx), stable, 1);
        inst_ready = 1'b1;
        if (sb.size() == 0) begin
            check($sformatf("vec%0d_sb_empty", idx), 0, 1);
        end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d_sb_entry", idx), {inst_pc, instw, fetch_err}, {e.pc, e.word, e.err});
        end
        check($sformatf("vec%0d_pc_err", idx), {inst_pc, fetch_err}, {v.pc, v.ferr});
        @(posedge clk);
        #1;
        resp_err_cfg = 1'b0;
    endtask

    initial begin : main
        logic [31:0] a;
        logic        sv;
        logic        ok;
        logic        bad;
        logic        saw_req;

        compared       = 0;
        mismatched     = 0;
        resp_delay     = 1;
        resp_err_cfg   = 1'b0;
        force_ebreak   = 1'b0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;

        vecs[0] = '{1, 1'b0, 0, 32'h8000_0000, 1'b0};
        vecs[1] = '{1, 1'b0, 0, 32'h8000_0004, 1'b0};
        vecs[2] = '{3, 1'b0, 5, 32'h8000_0008, 1'b0};
        vecs[3] = '{2, 1'b1, 0, 32'h8000_000C, 1'b1};
        vecs[4] = '{1, 1'b0, 2, 32'h8000_0010, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_outputs", {imem_req_valid, inst_valid, instw, inst_pc, fetch_err, halted}, 0);
        check("reset_req_addr", imem_req_addr, RESET_PC);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) fetch_one(vecs[i], i);

        // Redirect in WAIT in the same cycle as the response.
        sb.delete();
        inst_ready = 1'b0;
        resp_delay = 2;
        wait_req(a, sv);
        check("wait_redir_req_addr", a, 32'h8000_0014);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0100;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        wait_req(a, sv);
        check("wait_redir_next_addr", a, 32'h8000_0100);
        check("wait_redir_no_valid", sv, 0);
        wait_valid(ok);
        check("wait_redir_fetch", {ok, inst_pc, instw, fetch_err}, {1'b1, 32'h8000_0100, mem_word(32'h8000_0100), 1'b0});

        // Redirect in HOLD discards the held instruction.
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0008;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        check("hold_redir_drop", inst_valid, 0);
        wait_req(a, sv);
        check("hold_redir_addr", a, 32'h8000_0008);

        // Redirect together with inst_ready in HOLD.
        wait_valid(ok);
        check("hold_pc_8", {ok, inst_pc}, {1'b1, 32'h8000_0008});
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0200;
        inst_ready  = 1'b1;
        @(posedge clk);
        #1;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        check("redir_ready_drop", inst_valid, 0);
        wait_req(a, sv);
        check("redir_wins_over_inc", a, 32'h8000_0200);

        // Redirect to a misaligned PC: error without any request.
        wait_valid(ok);
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0102;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        saw_req  = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (imem_req_valid) saw_req = 1'b1;
            if (inst_valid) break;
        end
        check("misalign_out", {inst_valid, inst_pc, instw, fetch_err, saw_req},
              {1'b1, 32'h8000_0102, 32'h0, 1'b1, 1'b0});
        repeat (3) begin
            @(negedge clk);
            if (imem_req_valid) saw_req = 1'b1;
        end
        check("misalign_no_req", saw_req, 0);

        // Recover and fetch an ebreak.
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0300;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        wait_req(a, sv);
        check("recover_addr", a, 32'h8000_0300);
        force_ebreak = 1'b1;
        wait_valid(ok);
        check("ebreak_fetch", {ok, instw, fetch_err}, {1'b1, EBREAK, 1'b0});
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        inst_ready   = 1'b0;
        force_ebreak = 1'b0;
`ifdef YSYX_23060020_IFU_EBREAK_HALT_EN
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req_valid || inst_valid || !halted) bad = 1'b1;
            redirect    = (c == 5);
            redirect_pc = 32'h8000_0500;
        end
        redirect = 1'b0;
        check("halt_quiet", bad, 0);
        check("halted_set", halted, 1);
`else
        wait_req(a, sv);
        check("ebreak_no_halt", {a, halted}, {32'h8000_0304, 1'b0});
`endif

        // Reset, then abort a fetch with a second reset.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset2_outputs", {imem_req_valid, inst_valid, instw, inst_pc, fetch_err, halted}, 0);
        rst_n      = 1'b1;
        resp_delay = 3;
        wait_req(a, sv);
        check("post_reset_addr", {a, halted}, {RESET_PC, 1'b0});
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        @(negedge clk);
        check("midfetch_reset", {imem_req_valid, inst_valid, instw, inst_pc, fetch_err, halted, imem_req_addr},
              {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, RESET_PC});
        rst_n = 1'b1;
        bad   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (inst_valid || !imem_req_valid || imem_req_addr !== RESET_PC) bad = 1'b1;
        end
        check("stale_resp_ignored", bad, 0);

        // Redirect while a request is stalled: address held, response later dropped.
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0400;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        check("req_stable_on_redir", {imem_req_valid, imem_req_addr}, {1'b1, RESET_PC});
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        resp_delay     = 1;
        @(posedge clk);
        #1;
        wait_req(a, sv);
        check("stale_drop_next", {a, sv}, {32'h8000_0400, 1'b0});
        wait_valid(ok);
        check("final_fetch", {ok, inst_pc, instw}, {1'b1, 32'h8000_0400, mem_word(32'h8000_0400)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
